// File: rtl/system_avmm_pkg.sv
// Shared types and default widths for the Avalon-MM command master.
package system_avmm_pkg;

    localparam int unsigned SYSTEM_AVMM_ADDR_W = 2;
    localparam int unsigned SYSTEM_AVMM_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR     = 2'd1,
        ST_RD     = 2'd2,
        ST_RDWAIT = 2'd3
    } avmm_state_t;

endpackage

// File: rtl/system_avmm_timeout_cnt.sv
// Transaction watchdog: counts busy cycles from issue, flags the LIMIT-th cycle.
module system_avmm_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    // count holds the busy-cycle index, so the LIMIT-th busy cycle is the last one
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/system_avmm_cmd_master.sv
// Single-outstanding Avalon-MM master driven by a valid/ready command port.
// Optional watchdog enabled with `define SYSTEM_AVMM_TIMEOUT_EN.
module system_avmm_cmd_master
    import system_avmm_pkg::*;
#(
    parameter int unsigned ADDR_W         = SYSTEM_AVMM_ADDR_W,
    parameter int unsigned DATA_W         = SYSTEM_AVMM_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    avmm_state_t       state, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [DATA_W-1:0] rdata_q, rdata_n;
    logic              rsp_valid_q, rsp_valid_n;
    logic              rsp_err_q, rsp_err_n;
    logic              tmo_expired;

`ifdef SYSTEM_AVMM_TIMEOUT_EN
    system_avmm_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cmd_valid && (state == ST_IDLE)),
        .enable  (state != ST_IDLE),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state       <= state_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            rdata_q     <= rdata_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_err_q   <= rsp_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        rdata_n     = rdata_q;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_n  = cmd_addr;
                    wdata_n = cmd_wdata;
                    state_n = cmd_write ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                if (!avm_waitrequest) begin
                    rsp_valid_n = 1'b1;
                    state_n     = ST_IDLE;
                end else if (tmo_expired) begin
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                    rdata_n     = '0;
                    state_n     = ST_IDLE;
                end
            end
            ST_RD: begin
                // data returned alongside the accept cycle completes without visiting RDWAIT
                if (!avm_waitrequest && avm_readdatavalid) begin
                    rdata_n     = avm_readdata;
                    rsp_valid_n = 1'b1;
                    state_n     = ST_IDLE;
                end else if (tmo_expired) begin
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                    rdata_n     = '0;
                    state_n     = ST_IDLE;
                end else if (!avm_waitrequest) begin
                    state_n = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                if (avm_readdatavalid) begin
                    rdata_n     = avm_readdata;
                    rsp_valid_n = 1'b1;
                    state_n     = ST_IDLE;
                end else if (tmo_expired) begin
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                    rdata_n     = '0;
                    state_n     = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign cmd_ready     = (state == ST_IDLE);
    assign avm_write     = (state == ST_WR);
    assign avm_read      = (state == ST_RD);
    assign avm_address   = addr_q;
    assign avm_writedata = wdata_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rdata_q;
    assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_system_avmm_cmd_master.sv
// Self-checking bench for system_avmm_cmd_master: directed table, reset/timeout/back-to-back sequences, random traffic.
module tb_system_avmm_cmd_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [1:0]  avm_address;
    logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
    logic [31:0] avm_writedata, avm_readdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;

    always #5 clk = ~clk;

    system_avmm_cmd_master #(
        .ADDR_W         (2),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_addr          (cmd_addr),
        .cmd_wdata         (cmd_wdata),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .rsp_err           (rsp_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] model_rsp;

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        int          nwait;
        int          d;
        logic [31:0] rdata;
        int          exp_lat;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    bit          bw[3] = '{1'b1, 1'b0, 1'b1};
    logic [1:0]  ba[3] = '{2'd1, 2'd2, 2'd3};
    logic [31:0] bd[3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    logic [31:0] expq[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic zero_checks(input string tag);
        chk1({tag, " avm_read"}, avm_read, 1'b0);
        chk1({tag, " avm_write"}, avm_write, 1'b0);
        chk1({tag, " rsp_valid"}, rsp_valid, 1'b0);
        chk1({tag, " rsp_err"}, rsp_err, 1'b0);
        chk32({tag, " rsp_data"}, rsp_data, 32'h0);
        chk32({tag, " avm_address"}, 32'(avm_address), 32'h0);
        chk32({tag, " avm_writedata"}, avm_writedata, 32'h0);
    endtask

    // Called just after a negedge: reset mid-cycle, check outputs, release on the next negedge.
    task automatic pulse_reset(input string tag);
        #2 reset = 1'b1;
        #1 zero_checks(tag);
        @(negedge clk);
        reset = 1'b0;
        #1 chk1({tag, " cmd_ready after release"}, cmd_ready, 1'b1);
        model_rsp = 32'h0;
    endtask

    // Cycle i counts negedges from the command presentation (i=0). Strobe is visible
    // in cycles 1..1+nwait; the slave accepts in cycle k=1+nwait, read data arrives d
    // cycles later, and the response is visible at exp_lat (= k + d + 1).
    task automatic run_txn(input bit wr, input logic [1:0] addr, input logic [31:0] wdata,
                           input int nwait, input int d, input logic [31:0] rdata,
                           input int exp_lat, input logic [31:0] exp_data);
        int k;
        bit stb;
        k = 1 + nwait;
        for (int i = 0; i <= exp_lat + 1; i++) begin
            @(negedge clk);
            stb = (i >= 1) && (i <= k);
            chk1("avm_write", avm_write, wr && stb);
            chk1("avm_read", avm_read, !wr && stb);
            if (stb) begin
                chk32("avm_address", 32'(avm_address), 32'(addr));
                if (wr) chk32("avm_writedata", avm_writedata, wdata);
            end
            chk1("rsp_valid", rsp_valid, i == exp_lat);
            if (i >= exp_lat) begin
                chk32("rsp_data", rsp_data, exp_data);
                chk1("rsp_err", rsp_err, 1'b0);
            end
            chk1("cmd_ready", cmd_ready, (i == 0) || (i >= exp_lat));
            cmd_valid = (i == 0);
            if (i == 0) begin
                cmd_write = wr;
                cmd_addr  = addr;
                cmd_wdata = wdata;
            end else begin
                cmd_write = 1'($urandom);
                cmd_addr  = 2'($urandom);
                cmd_wdata = $urandom;
            end
            avm_waitrequest = stb ? (i <= nwait) : 1'($urandom);
            if (!wr && (i == k + d)) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = rdata;
            end else begin
                avm_readdata      = $urandom;
                avm_readdatavalid = (wr || (i == 0) || (i > k + d)) ? 1'($urandom) : 1'b0;
            end
        end
        cmd_valid         = 1'b0;
        avm_readdatavalid = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        cmd_valid         = 1'b0;
        cmd_write         = 1'b0;
        cmd_addr          = 2'd0;
        cmd_wdata         = 32'h0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = 32'h0;
        avm_readdatavalid = 1'b0;
        model_rsp         = 32'h0;

        vecs[0] = '{1'b1, 2'd0, 32'h1234_5678, 0, 0, 32'h0,         2, 32'h0};
        vecs[1] = '{1'b0, 2'd1, 32'h0,         3, 2, 32'hCAFE_F00D, 7, 32'hCAFE_F00D};
        vecs[2] = '{1'b0, 2'd2, 32'h0,         0, 0, 32'hA5A5_0001, 2, 32'hA5A5_0001};
        vecs[3] = '{1'b1, 2'd3, 32'hDEAD_BEEF, 2, 0, 32'h0,         4, 32'hA5A5_0001};
        vecs[4] = '{1'b0, 2'd3, 32'h0,         1, 3, 32'h0BAD_F00D, 6, 32'h0BAD_F00D};
        vecs[5] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 0, 0, 32'h0,         2, 32'h0BAD_F00D};

        repeat (3) @(negedge clk);
        zero_checks("reset");
        reset = 1'b0;
        #1 chk1("cmd_ready after release", cmd_ready, 1'b1);

        for (int v = 0; v < 6; v++)
            run_txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].nwait, vecs[v].d,
                    vecs[v].rdata, vecs[v].exp_lat, vecs[v].exp_data);

        // Reset while waiting for read data, then stray readdatavalid must be ignored.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd2; avm_waitrequest = 1'b0;
        @(negedge clk);
        chk1("rdwait setup avm_read", avm_read, 1'b1);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk1("rdwait avm_read low", avm_read, 1'b0);
        chk1("rdwait cmd_ready low", cmd_ready, 1'b0);
        pulse_reset("reset in RDWAIT");
        for (int i = 0; i < 4; i++) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = $urandom;
            @(negedge clk);
            chk1("spurious rdv rsp_valid", rsp_valid, 1'b0);
            chk1("spurious rdv cmd_ready", cmd_ready, 1'b1);
            chk32("spurious rdv rsp_data", rsp_data, 32'h0);
        end
        avm_readdatavalid = 1'b0;

        // Reset while the read strobe is stalled must drop it at once.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd3; avm_waitrequest = 1'b1;
        @(negedge clk);
        chk1("stalled read strobe", avm_read, 1'b1);
        cmd_valid = 1'b0;
        pulse_reset("reset in RD");
        avm_waitrequest = 1'b0;

`ifdef SYSTEM_AVMM_TIMEOUT_EN
        for (int c = 0; c < 2; c++) begin
            bit w;
            w = (c == 1);
            for (int i = 0; i <= 12; i++) begin
                @(negedge clk);
                chk1("tmo avm_write", avm_write, w && (i >= 1) && (i <= 8));
                chk1("tmo avm_read", avm_read, !w && (i == 1));
                chk1("tmo rsp_valid", rsp_valid, i == 9);
                if (i == 9) chk1("tmo rsp_err", rsp_err, 1'b1);
                if (i >= 9) chk32("tmo rsp_data", rsp_data, 32'h0);
                chk1("tmo cmd_ready", cmd_ready, (i == 0) || (i >= 9));
                cmd_valid         = (i == 0);
                cmd_write         = w;
                cmd_addr          = 2'd3;
                cmd_wdata         = 32'h5A5A_5A5A;
                avm_waitrequest   = w;
                avm_readdatavalid = !w && (i >= 9) && (i <= 11);
                avm_readdata      = $urandom | 32'h1;
            end
            avm_waitrequest   = 1'b0;
            avm_readdatavalid = 1'b0;
        end
        model_rsp = 32'h0;
`endif

        // Back-to-back: cmd_valid stays high, each command served in order.
        begin
            int ai, ci, rc, cyc, wcnt;
            ai = 0; ci = 0; rc = 0; cyc = 0; wcnt = 0;
            while ((rc < 3) && (cyc < 60)) begin
                @(negedge clk);
                cyc++;
                if (rsp_valid) begin
                    if (expq.size() > 0) chk32("b2b rsp_data", rsp_data, expq.pop_front());
                    else chk1("b2b rsp without txn", rsp_valid, 1'b0);
                    rc++;
                end
                if ((avm_write || avm_read) && (ci < 3)) begin
                    chk1("b2b cmd_ready low", cmd_ready, 1'b0);
                    chk1("b2b direction", avm_write, bw[ci]);
                    chk32("b2b address", 32'(avm_address), 32'(ba[ci]));
                    if (bw[ci]) chk32("b2b writedata", avm_writedata, bd[ci]);
                end
                if (ai < 3) begin
                    cmd_valid = 1'b1;
                    cmd_write = bw[ai];
                    cmd_addr  = ba[ai];
                    cmd_wdata = bd[ai];
                    if (cmd_ready) ai++;
                end else begin
                    cmd_valid = 1'b0;
                end
                avm_readdatavalid = 1'b0;
                if (avm_write || avm_read) begin
                    avm_waitrequest = (wcnt < 2) ? 1'($urandom) : 1'b0;
                    wcnt++;
                    if (!avm_waitrequest) begin
                        if (avm_read) begin
                            avm_readdatavalid = 1'b1;
                            avm_readdata      = 32'hB0B0_0000 | 32'(ci);
                            model_rsp         = avm_readdata;
                        end
                        expq.push_back(model_rsp);
                        ci++;
                        wcnt = 0;
                    end
                end else begin
                    avm_waitrequest = 1'b0;
                end
            end
            chk32("b2b response count", 32'(rc), 32'd3);
            cmd_valid         = 1'b0;
            avm_readdatavalid = 1'b0;
            avm_waitrequest   = 1'b0;
        end

        // Random traffic against the latency/data rules.
        for (int t = 0; t < 40; t++) begin
            bit          wr;
            int          nw, dd, lat;
            logic [31:0] wd, rd, ed;
            wr  = 1'($urandom);
            nw  = int'($urandom_range(0, 3));
            dd  = wr ? 0 : int'($urandom_range(0, 3));
            wd  = $urandom;
            rd  = $urandom;
            lat = 2 + nw + dd;
            ed  = wr ? model_rsp : rd;
            run_txn(wr, 2'($urandom), wd, nw, dd, rd, lat, ed);
            model_rsp = ed;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
